coin_acceptor: RTL and testbench

//  Front end of the vending machine. Turns raw coin-chute sensor levels into clean
//  one-cycle one-hot coin codes on the coin[4:0] bus that feeds VendingMoore.
//  - Synchronises the sensors and debounces them.
//  - Rejects multi-sensor (invalid) events.
//  - Enforces a hold-off so one coin yields exactly one code.

---
 rtl/coin_acceptor.sv | 166 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-chute front end for the vending machine.
// Synchronises and debounces the four chute sensors, rejects multi-sensor
// events and holds off after each event so one coin yields one code.
// Optional feature: define COIN_COUNT_EN to add the total_cents accumulator.
//
// Handshake: there is none. coin and reject are one-cycle pulses with no
// back-pressure; the consumer must sample them every cycle.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sense,
    output logic [4:0]  coin,
    output logic        reject,
    output logic        busy
`ifdef COIN_COUNT_EN
    ,
    output logic [15:0] total_cents
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        EMIT    = 3'd2,
        REJECT  = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      s_meta_q, s_sync_q;
    logic [3:0]      pat_q, pat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [4:0]      coin_q;
    logic            reject_q;
    logic            busy_q;

    // A pattern is accepted only if exactly one sensor is set.
    function automatic logic is_one_hot(input logic [3:0] p);
        return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
    endfunction

    // Two-flop synchroniser for the asynchronous sensor levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_meta_q <= 4'd0;
            s_sync_q <= 4'd0;
        end else begin
            s_meta_q <= sense;
            s_sync_q <= s_meta_q;
        end
    end

    // FSM state, latched pattern and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= 4'd0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Next-state logic: qualify a stable pattern, emit or reject, then hold off.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            IDLE: begin
                if (s_sync_q != 4'd0) begin
                    pat_d   = s_sync_q;
                    cnt_d   = CW'(1);
                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                if (s_sync_q != pat_q) begin
                    // Glitch or pattern change: drop it without output.
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = is_one_hot(pat_q) ? EMIT : REJECT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EMIT, REJECT: begin
                hcnt_d  = '0;
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (s_sync_q != 4'd0) begin
                    // Coin still in the chute or chattering: restart the wait.
                    hcnt_d = '0;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            coin_q   <= 5'd0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            coin_q   <= (state_d == EMIT) ? {1'b0, pat_d} : 5'd0;
            reject_q <= (state_d == REJECT);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = busy_q;

`ifdef COIN_COUNT_EN
    logic [15:0] total_q;
    logic [6:0]  coin_value;
    logic [16:0] total_sum;

    // Cent value of the pattern currently being emitted.
    always_comb begin
        coin_value = 7'd0;
        unique case (pat_q)
            4'b0001: coin_value = 7'd25;
            4'b0010: coin_value = 7'd50;
            4'b0100: coin_value = 7'd75;
            4'b1000: coin_value = 7'd100;
            default: coin_value = 7'd0;
        endcase
        total_sum = {1'b0, total_q} + {10'd0, coin_value};
    end

    // Saturating accumulator, updated on the edge that leaves EMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            total_q <= 16'd0;
        end else if (state_q == EMIT) begin
            total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    assign total_cents = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenarios plus randomized sensor traffic,
// checked every cycle against a run-length model of the acceptor.
module tb_coin_acceptor;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sense = 4'd0;
  logic [4:0] coin;
  logic       reject;
  logic       busy;
`ifdef COIN_COUNT_EN
  logic [15:0] total_cents;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sense (sense),
    .coin  (coin),
    .reject(reject),
    .busy  (busy)
`ifdef COIN_COUNT_EN
    ,
    .total_cents(total_cents)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // The acceptor sees each sensor value two edges late. While armed it
  // measures the run length of a nonzero pattern (a changed sample is
  // discarded and the run restarts from the following sample). A run of
  // DEB equal samples fires one output cycle; the sample during that cycle
  // is ignored, then HOLD consecutive zero samples are needed to re-arm.
  logic [3:0] h1 = 4'd0, h2 = 4'd0;
  int         m_run   = 0;
  logic [3:0] m_pat   = 4'd0;
  bit         m_fire  = 1'b0;
  logic [4:0] m_fire_coin = 5'd0;
  bit         m_armed = 1'b1;
  int         m_zeros = 0;
  int         m_total = 0;
  logic [4:0] exp_coin = 5'd0;
  bit         exp_rej  = 1'b0;
  bit         exp_busy = 1'b0;

  function automatic int cents(logic [4:0] c);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (c[i]) v = 25 * (i + 1);
    return v;
  endfunction

  always @(posedge clk) begin
    logic [3:0] s;
    cyc++;
    if (!reset) begin
      h1 = 4'd0; h2 = 4'd0;
      m_run = 0; m_fire = 1'b0; m_armed = 1'b1; m_zeros = 0; m_total = 0;
      exp_coin = 5'd0; exp_rej = 1'b0;
    end else begin
      s  = h2;
      h2 = h1;
      h1 = sense;
      exp_coin = 5'd0;
      exp_rej  = 1'b0;
      if (m_fire) begin
        if (m_fire_coin != 5'd0) begin
          m_total = m_total + cents(m_fire_coin);
          if (m_total > 65535) m_total = 65535;
        end
        m_fire = 1'b0; m_armed = 1'b0; m_zeros = 0;
      end else if (!m_armed) begin
        if (s == 4'd0) m_zeros++; else m_zeros = 0;
        if (m_zeros == HOLD) m_armed = 1'b1;
      end else if (m_run == 0) begin
        if (s != 4'd0) begin m_run = 1; m_pat = s; end
      end else if (s == m_pat) begin
        m_run++;
        if (m_run == DEB) begin
          m_run  = 0;
          m_fire = 1'b1;
          if ($countones(m_pat) == 1) exp_coin = {1'b0, m_pat};
          else exp_rej = 1'b1;
          m_fire_coin = exp_coin;
        end
      end else begin
        m_run = 0;
      end
    end
    exp_busy = m_fire || !m_armed || (m_run != 0);
  end

  // ---------------- per-cycle compare (scoreboard) ----------------
  int         coin_pulses = 0;
  int         rej_pulses  = 0;
  logic [4:0] last_coin   = 5'd0;
  int         coin_cyc    = 0;
  int         busy_rise   = 0;
  int         busy_fall   = 0;
  bit         busy_prev   = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("coin", coin, exp_coin);
      check("reject", reject, exp_rej);
      check("busy", busy, exp_busy);
      check("coin_reject_exclusive", (coin != 5'd0) && reject, 0);
`ifdef COIN_COUNT_EN
      check("total_cents", total_cents, m_total);
`endif
      if (coin != 5'd0) begin coin_pulses++; last_coin = coin; coin_cyc = cyc; end
      if (reject) rej_pulses++;
      if (busy && !busy_prev) busy_rise = cyc;
      if (!busy && busy_prev) busy_fall = cyc;
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(logic [3:0] v, int n);
    sense = v;
    tick(n);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int p0, r0, e0, rst_edge;
    logic [3:0] pat;

    reset = 1'b0;
    sense = 4'd0;
    tick(3);
    check("reset_coin", coin, 0);
    check("reset_reject", reject, 0);
    check("reset_busy", busy, 0);
    chk_en = 1'b1;
    reset  = 1'b1;
    tick(2);

    // 1: quarter held 12 cycles -> one pulse, 6 edges after assert
    p0 = coin_pulses; r0 = rej_pulses;
    e0 = cyc + 1;
    hold(4'b0001, 12);
    hold(4'b0000, 20);
    check("t1_pulses", coin_pulses - p0, 1);
    check("t1_code", last_coin, 5'b00001);
    check("t1_latency", coin_cyc, e0 + 5);
    check("t1_busy_rise", busy_rise, e0 + 2);
    check("t1_busy_fall", busy_fall, e0 + 21);
    check("t1_rejects", rej_pulses - r0, 0);

    // 2: short glitch is filtered
    p0 = coin_pulses; r0 = rej_pulses;
    hold(4'b0010, 2);
    hold(4'b0000, 20);
    check("t2_pulses", coin_pulses - p0, 0);
    check("t2_rejects", rej_pulses - r0, 0);
    check("t2_idle", busy, 0);

    // 3: two sensors at once -> single reject
    p0 = coin_pulses; r0 = rej_pulses;
    hold(4'b0011, 10);
    hold(4'b0000, 20);
    check("t3_rejects", rej_pulses - r0, 1);
    check("t3_pulses", coin_pulses - p0, 0);

    // 4: chatter inside hold-off -> still one dollar
    p0 = coin_pulses;
    hold(4'b1000, 8);
    hold(4'b0000, 3);
    hold(4'b1000, 5);
    hold(4'b0000, 25);
    check("t4_pulses", coin_pulses - p0, 1);
    check("t4_code", last_coin, 5'b01000);

    // 5: reset in 3rd QUALIFY cycle -> fresh qualification needed
    p0 = coin_pulses;
    hold(4'b0100, 5);
    reset = 1'b0;
    tick(1);
    rst_edge = cyc;
    check("t5_reset_coin", coin, 0);
    check("t5_reset_reject", reject, 0);
    check("t5_reset_busy", busy, 0);
    check("t5_no_early", coin_pulses - p0, 0);
    reset = 1'b1;
    tick(10);
    hold(4'b0000, 20);
    check("t5_pulses", coin_pulses - p0, 1);
    check("t5_code", last_coin, 5'b00100);
    check("t5_latency", coin_cyc, rst_edge + 6);

`ifdef COIN_COUNT_EN
    // 6: quarter + fifty + fifty = 125; reject adds nothing
    reset = 1'b0; tick(1); reset = 1'b1; tick(2);
    hold(4'b0001, 6); hold(4'b0000, 20);
    hold(4'b0010, 6); hold(4'b0000, 20);
    hold(4'b0010, 6); hold(4'b0000, 20);
    check("t6_total", total_cents, 125);
    hold(4'b0011, 6); hold(4'b0000, 20);
    check("t6_total_after_reject", total_cents, 125);

    // saturation: 700 dollars exceed 16 bits
    for (int i = 0; i < 700; i++) begin
      hold(4'b1000, 5);
      hold(4'b0000, 10);
    end
    check("t6_saturate", total_cents, 16'hFFFF);
    reset = 1'b0; tick(1); reset = 1'b1;
    check("t6_total_reset", total_cents, 0);
`endif

    // randomized traffic with occasional resets
    repeat (300) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        pat = 4'b0001 << $urandom_range(0, 3);
      end else if (r < 70) begin
        pat = 4'd0;
      end else begin
        pat = 4'($urandom_range(1, 15));
      end
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end
      hold(pat, $urandom_range(1, 14));
    end
    hold(4'b0000, 30);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
